// File: rtl/addsub_nibble_sequencer.sv
// addsub_nibble_sequencer
// Multi-cycle wide add/subtract built around one 4-bit add/sub slice.
// One nibble is processed per clock, least significant first, with the
// carry chained through a register between slices.
//
// Handshake: start is accepted only while busy=0 (IDLE or DONE state).
// An accepted start samples a, b and mode at that edge; later changes on
// those inputs are ignored. done is a one-cycle pulse, and result/cout/ovf
// are valid from that cycle until the next operation completes.
//
// Optional feature macro: ADDSUB_SEQ_OVF_EN
//   defined     -> ovf reports signed overflow of the completed operation
//   not defined -> ovf is tied to 0 and no overflow logic exists
//
// state_dbg exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for observation.
module addsub_nibble_sequencer #(
  parameter int NIBBLES = 4  // legal range 2..16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic [1:0]             state_dbg
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // Latched operands and per-operation working registers
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             mode_q;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     acc;

  // Combinational slice datapath
  logic             accept;
  logic             last_slice;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       b_eff;
  logic [4:0]       slice_sum;
  logic [W-1:0]     acc_next;

  // Accept decision: start counts only when not busy
  always_comb begin
    accept     = 1'b0;
    last_slice = 1'b0;
    accept     = start && ((state == IDLE) || (state == DONE));
    last_slice = (idx == IDX_W'(NIBBLES - 1));
  end

  // Next-state logic; outputs decoded directly from the state
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A start in the DONE cycle chains straight into the next run
        if (accept) next_state = RUN;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign state_dbg = state;

  // 4-bit add/sub slice: subtract is a + ~b + 1, with the +1 coming from
  // the carry register that is seeded with mode on accept
  always_comb begin
    a_nib     = a_q[{idx, 2'b00} +: 4];
    b_nib     = b_q[{idx, 2'b00} +: 4];
    b_eff     = b_nib ^ {4{mode_q}};
    slice_sum = {1'b0, a_nib} + {1'b0, b_eff} + {4'd0, carry};
    acc_next  = acc;
    acc_next[{idx, 2'b00} +: 4] = slice_sum[3:0];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand latch, slice index, carry chain and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      acc    <= '0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      idx    <= '0;
      carry  <= mode;
    end else if (state == RUN) begin
      acc    <= acc_next;
      carry  <= slice_sum[4];
      if (!last_slice) idx <= idx + 1'b1;
    end
  end

  // Registered outputs update only when the last slice completes
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cout   <= 1'b0;
    end else if ((state == RUN) && last_slice) begin
      result <= acc_next;
      cout   <= slice_sum[4];
    end
  end

`ifdef ADDSUB_SEQ_OVF_EN
  logic sign_a;
  logic sign_b_eff;

  always_comb begin
    sign_a     = a_q[W-1];
    sign_b_eff = b_q[W-1] ^ mode_q;
  end

  // Signed overflow: operands of equal effective sign, result sign differs
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == RUN) && last_slice) begin
      ovf <= (sign_a == sign_b_eff) && (acc_next[W-1] != sign_a);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Directed testbench for addsub_nibble_sequencer with NIBBLES=4.
module tb_addsub_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

`ifdef ADDSUB_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [1:0]   state_dbg;

  int passed = 0;
  int total  = 0;

  addsub_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue a start from a non-busy state, then watch the whole operation:
  // four RUN cycles with busy=1, done=0 and the old result held, then done.
  task automatic do_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input logic op_mode, input logic [W-1:0] exp_res,
                       input logic exp_cout, input logic exp_ovf);
    logic [W-1:0] prev_res;
    int busy_cnt;
    int bad_run;
    @(negedge clk);
    prev_res = result;
    start = 1'b1; a = op_a; b = op_b; mode = op_mode;
    @(posedge clk);
    #1;
    start = 1'b0; a = '1; b = '1; mode = ~op_mode;  // scramble: must not matter
    busy_cnt = 0;
    bad_run  = 0;
    for (int i = 0; i < NIBBLES; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b0 || result !== prev_res) bad_run++;
    end
    check({tag, "_busy_cycles"}, busy_cnt, NIBBLES);
    check({tag, "_run_hold"}, bad_run, 0);
    @(negedge clk);
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_ovf"}, ovf, exp_ovf);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int cnt;
    int cyc;
    // Reset
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 16'h0000);
    check("reset_cout", cout, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_state", state_dbg, 2'd0);
    rst = 1'b0;

    // Basic add and subtract cases
    do_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON);

    // Busy protection: a start in the second RUN cycle is ignored
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);                       // RUN cycle 1
    @(negedge clk);                       // RUN cycle 2
    start = 1'b1; a = 16'hAAAA; b = 16'h0001; mode = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);                       // RUN cycle 3
    @(negedge clk);                       // RUN cycle 4
    check("busyprot_still_busy", busy, 1'b1);
    @(negedge clk);
    check("busyprot_done", done, 1'b1);
    check("busyprot_result", result, 16'h3333);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    check("busyprot_no_extra", cnt, 0);
    check("busyprot_idle", state_dbg, 2'd0);
    do_op("after_idle", 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0);

    // Back-to-back: start held during the DONE cycle
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (NIBBLES) @(negedge clk);
    @(negedge clk);
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_result", result, 16'h3333);
    start = 1'b1; a = 16'h0010; b = 16'h0001; mode = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) break;
    end
    check("b2b_gap", cyc, 5);
    check("b2b_second_result", result, 16'h000F);
    check("b2b_second_cout", cout, 1'b1);
    check("b2b_second_ovf", ovf, 1'b0);

    // Reset in the second RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h0FFF; mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);                       // RUN cycle 1
    @(negedge clk);                       // RUN cycle 2
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_cout", cout, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    check("rst_no_done", cnt, 0);
    do_op("after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
